fetch_unit: RTL
===============

# fetch_unit

Parametrised instruction fetch unit. It sits between the memory controller, the branch predictor and the dispatcher. It holds a direct-mapped, line-based instruction cache that refills a whole line per miss, and queries the predictor combinationally for the current PC. Fetched instructions are buffered in a configurable-depth FIFO drained by a valid/ready handshake. A redirect/flush input clears the queue and restarts fetch from a new PC.

## Interface
- RESET_PC, 32'h0: fetch PC after reset
- IDX_W, 6: log2 of cache line count (64 lines)
- LW_W, 2: log2 of words per line (4 words = 16 B)
- IQ_W, 3: log2 of queue depth (8 entries)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global enable; low = all state holds
- mem_req  out  1  line refill request
- mem_addr  out  32  line base address
- mem_valid  in  1  one refill word delivered this cycle
- mem_data  in  32  delivered word
- pred_pc  out  32  current fetch PC
- pred_inst  out  32  cached instruction at pred_pc on hit, 0 on miss
- pred_taken  in  1  predictor says taken
- pred_target  in  32  absolute predicted target
- iq_valid  out  1  queue head valid
- iq_inst  out  32  head instruction
- iq_pc  out  32  head PC
- iq_pred_taken  out  1  head prediction bit
- disp_ready  in  1  dispatcher accepts head
- flush_in  in  1  redirect request
- flush_pc  in  32  redirect target

## Operation
- Address split: offset = pc[LW_W+1:2]; index = pc[IDX_W+LW_W+1:LW_W+2]; tag = pc[31:IDX_W+LW_W+2]. pc[1:0] is ignored and treated as 0.
- Hit = valid[index] and tag_array[index] == tag.
- FSM states are FETCH and REFILL. Reset enters FETCH.
- FETCH, hit, queue count < 2^IQ_W:
  - Enqueue {inst, pc, pred_taken}.
  - Next pc = pred_taken ? pred_target : pc+4 (32-bit wrap).
- FETCH, hit, queue full: pc holds and nothing is enqueued. Fullness is evaluated on the pre-edge count; a same-cycle dequeue does not free a slot.
- FETCH, miss: next state is REFILL. mem_req becomes 1 and mem_addr becomes {pc[31:LW_W+2], 0}, both registered.
- REFILL:
  - Each mem_valid writes mem_data into word slot cnt of the line buffer; cnt increments.
  - Words arrive in ascending address order.
  - On the 2^LW_W-th word: write the data, tag and valid bit of the line; drop mem_req; return to FETCH.
  - mem_addr holds throughout REFILL.
- Dequeue happens when iq_valid and disp_ready are both high at a rising edge.
- iq_valid = (count != 0) and not flush_in.
- iq_inst, iq_pc and iq_pred_taken are driven from head storage and are meaningful only when iq_valid is high.
- Flush (flush_in at an edge):
  - Queue count is cleared and pc becomes flush_pc.
  - Flush takes priority over both enqueue and dequeue in the same cycle.
  - An in-progress refill is not aborted: mem_req stays high until the line completes, and the line is installed under its original address.
  - FETCH then resumes at flush_pc.
- The memory controller shares rdy_in and never pulses mem_valid while rdy_in is low.
- Cache valid bits reset to 0. Data and tag arrays need no reset.

## Timing
- Reset values: mem_req 0, mem_addr 0, iq_valid 0, iq_inst 0, iq_pc 0, iq_pred_taken 0, pc RESET_PC, FSM FETCH, count 0, cnt 0.
- Reset is asynchronous: outputs reach reset values without waiting for a clock edge, including mid-refill.
- Hit-to-iq_valid latency: 1 cycle. Sustained throughput is 1 instruction per cycle on hits with disp_ready high.
- Miss detected at edge N: mem_req is high after edge N.
- The last mem_valid at edge M installs the line. The fetch at edge M+1 hits and enqueues, so iq_valid is high after M+1.
- Queue pointers wrap modulo 2^IQ_W. Count ranges 0..2^IQ_W.
- Simultaneous enqueue and dequeue leaves count unchanged.

## Test plan
- Cold start, RESET_PC=0:
  - Stimulus: 4 mem_valid words 0x00000013, 0x00100093, 0x00200113, 0x00300193.
  - Required: mem_addr=0x0; then iq_pc 0x0, 0x4, 0x8, 0xC on consecutive cycles; then mem_req with mem_addr=0x10.
- Queue full:
  - Stimulus: disp_ready=0 with a warm cache.
  - Required: exactly 8 entries enqueued and pc frozen at 0x20. One disp_ready pulse frees one slot, then exactly one further enqueue of pc 0x20.
- Predicted taken:
  - Stimulus: pred_taken=1, pred_target=0x40 while pc=0x8.
  - Required: the entry at 0x8 carries iq_pred_taken=1, a refill of 0x40 follows, and the next iq_pc is 0x40.
- Flush mid-refill:
  - Stimulus: flush_pc=0x100 after 2 of 4 words of line 0x10.
  - Required: queue empties and mem_req stays high until the 4th word. Line 0x10 becomes valid. The next refill uses mem_addr=0x100.
- Aliasing:
  - Stimulus: fetch 0x0, then 0x400 (same index, different tag).
  - Required: refill at 0x400 evicts line 0x0. A later fetch of 0x0 misses again.
- Async reset during REFILL and during a full queue:
  - Stimulus: assert rst_in between clock edges.
  - Required: mem_req and iq_valid go 0 immediately. After release, fetch restarts at RESET_PC with a cold-cache miss.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: direct-mapped line cache with whole-line refill,
// combinational predictor lookup and a valid/ready instruction queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          IDX_W    = 6,
  parameter int          LW_W     = 2,
  parameter int          IQ_W     = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic [31:0] pred_pc,
  output logic [31:0] pred_inst,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_pred_taken,
  input  logic        disp_ready,
  input  logic        flush_in,
  input  logic [31:0] flush_pc
);
  localparam int LINES   = 1 << IDX_W;
  localparam int WORDS   = 1 << LW_W;
  localparam int DEPTH   = 1 << IQ_W;
  localparam int IDX_LSB = LW_W + 2;
  localparam int TAG_LSB = IDX_W + LW_W + 2;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic {S_FETCH = 1'b0, S_REFILL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [LW_W-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [IQ_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [IQ_W:0]     count_q, count_d;

  logic [31:0]       data_mem [LINES][WORDS];
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [31:0]       iq_inst_q [DEPTH];
  logic [31:0]       iq_pc_q [DEPTH];
  logic [DEPTH-1:0]  iq_taken_q;

  logic [LW_W-1:0]   fetch_off;
  logic [IDX_W-1:0]  fetch_idx, refill_idx;
  logic [TAG_W-1:0]  fetch_tag, refill_tag;
  logic              hit;
  logic [31:0]       fetch_inst;
  logic              enq, deq, word_wr, line_done;

  assign fetch_off  = pc_q[IDX_LSB-1:2];
  assign fetch_idx  = pc_q[TAG_LSB-1:IDX_LSB];
  assign fetch_tag  = pc_q[31:TAG_LSB];
  assign refill_idx = mem_addr_q[TAG_LSB-1:IDX_LSB];
  assign refill_tag = mem_addr_q[31:TAG_LSB];
  assign hit        = valid_q[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign fetch_inst = data_mem[fetch_idx][fetch_off];

  assign mem_req       = mem_req_q;
  assign mem_addr      = mem_addr_q;
  assign pred_pc       = pc_q;
  assign pred_inst     = hit ? fetch_inst : '0;
  assign iq_valid      = (count_q != '0) && !flush_in;
  assign iq_inst       = iq_inst_q[head_q];
  assign iq_pc         = iq_pc_q[head_q];
  assign iq_pred_taken = iq_taken_q[head_q];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    enq        = 1'b0;
    deq        = 1'b0;
    word_wr    = 1'b0;
    line_done  = 1'b0;
    if (rdy_in) begin
      deq = iq_valid && disp_ready;
      case (state_q)
        S_FETCH: begin
          // A redirect wins over both the hit path and starting a refill.
          if (!flush_in) begin
            if (hit) begin
              if (count_q < (IQ_W+1)'(DEPTH)) begin
                enq  = 1'b1;
                pc_d = pred_taken ? pred_target : pc_q + 32'd4;
              end
            end else begin
              state_d    = S_REFILL;
              mem_req_d  = 1'b1;
              mem_addr_d = {pc_q[31:IDX_LSB], {IDX_LSB{1'b0}}};
            end
          end
        end
        S_REFILL: begin
          if (mem_valid) begin
            word_wr = 1'b1;
            cnt_d   = cnt_q + LW_W'(1);
            if (cnt_q == '1) begin
              line_done           = 1'b1;
              valid_d[refill_idx] = 1'b1;
              mem_req_d           = 1'b0;
              state_d             = S_FETCH;
            end
          end
        end
        default: state_d = S_FETCH;
      endcase
      if (flush_in) begin
        pc_d    = flush_pc;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (enq) tail_d = tail_q + IQ_W'(1);
        if (deq) head_d = head_q + IQ_W'(1);
        case ({enq, deq})
          2'b10:   count_d = count_q + (IQ_W+1)'(1);
          2'b01:   count_d = count_q - (IQ_W+1)'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      valid_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      iq_taken_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        iq_inst_q[i] <= '0;
        iq_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (enq) begin
        iq_inst_q[tail_q]  <= fetch_inst;
        iq_pc_q[tail_q]    <= pc_q;
        iq_taken_q[tail_q] <= pred_taken;
      end
    end
  end

  // Words land directly in the array; the line is only visible once its
  // valid bit and tag are written with the last word.
  always_ff @(posedge clk_in) begin
    if (word_wr) data_mem[refill_idx][cnt_q] <= mem_data;
    if (line_done) tag_mem[refill_idx] <= refill_tag;
  end
endmodule
